// File: rtl/rdy_vld_pkg.sv
// Shared definitions for rdy/vld channel blocks.
// cnt_w() lets consumers size occupancy counters exactly as the FIFO does.
package rdy_vld_pkg;

    function automatic int unsigned cnt_w(input int unsigned depth);
        return 32'($clog2(depth + 1));
    endfunction

endpackage

// File: rtl/rdy_vld_if.sv
// Ready/valid handshake channel carrying a parametrised payload type.
// src drives vld/vld_data; dst drives rdy.
interface rdy_vld_if #(
    parameter type T = logic [1:0]
) ();
    logic vld;
    logic rdy;
    T     vld_data;

    modport src (output vld, output vld_data, input rdy);
    modport dst (input vld, input vld_data, output rdy);
endinterface

// File: rtl/wrap_ctr.sv
// Pointer counter that wraps from MAX-1 to 0 for any MAX, with sync reset/clear.
module wrap_ctr #(
    parameter int unsigned MAX = 4,
    parameter int unsigned W   = $clog2(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (inc) begin
            q <= (q == W'(MAX - 1)) ? '0 : q + W'(1);
        end
    end

endmodule

// File: rtl/rdy_vld_fifo.sv
// Synchronous rdy/vld FIFO with DEPTH entries, fill status and synchronous flush.
// No fall-through: a pushed entry becomes visible on out the following cycle.
module rdy_vld_fifo
    import rdy_vld_pkg::*;
#(
    parameter type         vld_data_st  = logic [1:0],
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned AFULL_THRESH = DEPTH - 1,
    localparam int unsigned CNT_W       = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    rdy_vld_if.dst           in,
    rdy_vld_if.src           out,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             almost_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    vld_data_st       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             in_rdy_c;
    logic             push_c;
    logic             pop_c;
    logic [CNT_W-1:0] cnt_nxt_c;

    // Upstream ready ignores out.rdy: a full FIFO never pushes in the cycle it pops.
    assign in_rdy_c     = !full && !flush && !rst;
    assign push_c       = in.vld && in_rdy_c;
    assign pop_c        = out.rdy && !empty;
    assign in.rdy       = in_rdy_c;
    assign out.vld      = !empty;
    assign out.vld_data = mem[rd_ptr];

    wrap_ctr #(.MAX(DEPTH), .W(PTR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (push_c),
        .q   (wr_ptr)
    );

    wrap_ctr #(.MAX(DEPTH), .W(PTR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (pop_c),
        .q   (rd_ptr)
    );

    always_comb begin
        cnt_nxt_c = count;
        if (flush) begin
            cnt_nxt_c = '0;
        end else if (push_c && !pop_c) begin
            cnt_nxt_c = count + CNT_W'(1);
        end else if (pop_c && !push_c) begin
            cnt_nxt_c = count - CNT_W'(1);
        end
    end

    // Status flags are registered from the next count so they track count exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            count       <= cnt_nxt_c;
            empty       <= (cnt_nxt_c == '0);
            full        <= (cnt_nxt_c == CNT_W'(DEPTH));
            almost_full <= (cnt_nxt_c >= CNT_W'(AFULL_THRESH));
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= in.vld_data;
        end
    end

endmodule
